sdspi_master: RTL and testbench
===============================

SDSPI_MASTER -- requirements
Module: sdspi_master

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning bits per transfer, legal range 8..32.
REQ-002 SHALL have parameter DIV_W, default 8, meaning width of the clock-divider setting.
REQ-003 SHALL have port fclk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1, meaning reset; asynchronous and active-high.
REQ-005 SHALL have port clkdiv, input, DIV_W, meaning SPI half-period in fclk cycles, minus 1.
REQ-006 SHALL have port cs_req_n, input, 1, meaning requested sdcs_n level.
REQ-007 SHALL have port start, input, 1, meaning a request to begin a transfer.
REQ-008 SHALL have port tx_data, input, DATA_W, meaning the word to send, MSB first.
REQ-009 SHALL have port rx_data, output, DATA_W, meaning the last received word.
REQ-010 SHALL have port busy, output, 1, meaning a transfer is in progress.
REQ-011 SHALL have port done, output, 1, meaning a single-cycle transfer-complete pulse.
REQ-012 SHALL have port sdcs_n, output, 1, meaning SD card chip select.
REQ-013 SHALL have port sdclk, output, 1, meaning SD card SPI clock.
REQ-014 SHALL have port sddo, output, 1, meaning data to the card.
REQ-015 SHALL have port sddi, input, 1, meaning data from the card.

Function
REQ-016 SHALL implement SPI mode 0: sdclk idles low; sddi sampled on sdclk rising; sddo changes on sdclk falling.
REQ-017 SHALL use a state machine with states IDLE, PH_LO and PH_HI.
- IDLE -> PH_LO: on an accepted start.
- PH_LO -> PH_HI: when the divider count expires.
- PH_HI -> PH_LO: when the divider count expires and bits remain.
- PH_HI -> IDLE: when the divider count expires on the last bit.
REQ-018 SHALL accept start only while busy=0; start while busy=1 SHALL be ignored with no queueing.
REQ-019 SHALL, when start is accepted in cycle t, latch tx_data and clkdiv, and assert busy and drive sddo=tx_data[DATA_W-1] from cycle t+1.
REQ-020 SHALL hold each sdclk phase for exactly clkdiv+1 fclk cycles, using the value latched at start; clkdiv changes mid-transfer SHALL have no effect.
REQ-021 SHALL register sddi into the receive shift register on the cycle sdclk goes high.
REQ-022 SHALL shift sddo to the next bit on the cycle sdclk goes low.
REQ-023 SHALL complete a transfer in exactly 2*DATA_W*(clkdiv+1) cycles of busy=1.
REQ-024 SHALL, in the cycle after the last PH_HI phase, assert done=1 for one cycle, deassert busy, drive sdclk=0 and sddo=1, and update rx_data.
REQ-025 SHALL hold rx_data stable until the next done.
REQ-026 SHALL accept a start asserted in the done cycle, giving back-to-back transfers with one idle cycle between them.
REQ-027 SHALL register sdcs_n from cs_req_n only while busy=0; a change during a transfer SHALL take effect the cycle after done.
REQ-028 SHALL implement the divider and bit counters as wrap-free down-counters; clkdiv=0 SHALL give sdclk=fclk/2.

Reset
REQ-029 SHALL, while rst=1, force asynchronously: state IDLE, busy=0, done=0, sdclk=0, sddo=1, sdcs_n=1, rx_data=0, all counters 0.
REQ-030 SHALL abort any transfer in progress on a reset asserted mid-transfer, without generating done.
REQ-031 SHALL accept start no earlier than the first fclk edge after rst falls.

Structure
REQ-032 SHALL place the state encoding and the DATA_W/DIV_W defaults in the shared package sdload_pkg.
REQ-033 SHALL be a single module with no sub-module; the divider is inline.

Verification
REQ-034 SHALL cover: DATA_W=8, clkdiv=0, tx_data=0xA5, sddi looped to sddo -> rx_data=0xA5; done exactly 16 cycles after busy rises; 8 sdclk pulses.
REQ-035 SHALL cover: clkdiv=3, sddi=1, tx_data=0x00 -> rx_data=0xFF; sdclk high and low each 4 cycles; done after 64 cycles; sddo=0 throughout the transfer, 1 after.
REQ-036 SHALL cover: start pulsed again at cycle 5 of a transfer -> ignored; exactly one done; start in the done cycle -> second transfer begins the next cycle.
REQ-037 SHALL cover: cs_req_n 1->0 mid-transfer -> sdcs_n stays 1 until the cycle after done, then 0.
REQ-038 SHALL cover: rst asserted mid-transfer -> same-cycle sdclk=0, sddo=1, sdcs_n=1, busy=0; no done pulse.
REQ-039 SHALL cover: DATA_W=16, clkdiv=1, tx_data=0x1234, loopback -> rx_data=0x1234; done after 64 cycles.

Source files
------------

// File: rtl/sdload_pkg.sv
// Shared definitions for the SD-card SPI master: default widths and
// the transfer state encoding.
package sdload_pkg;

    localparam int SDLOAD_DATA_W = 8;
    localparam int SDLOAD_DIV_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PH_LO = 2'd1,
        PH_HI = 2'd2
    } sdspi_state_t;

endpackage

// File: rtl/sdspi_master.sv
// SPI mode-0 master for an SD card, one DATA_W-bit word per start.
// Ports: fclk/rst, clkdiv (half-period - 1), cs_req_n, start, tx_data in;
// rx_data, busy, done out; sdcs_n, sdclk, sddo, sddi card pins.
module sdspi_master
    import sdload_pkg::*;
#(
    parameter int DATA_W = SDLOAD_DATA_W,
    parameter int DIV_W  = SDLOAD_DIV_W
) (
    input  logic              fclk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  clkdiv,
    input  logic              cs_req_n,
    input  logic              start,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              busy,
    output logic              done,
    output logic              sdcs_n,
    output logic              sdclk,
    output logic              sddo,
    input  logic              sddi
);

    localparam int CNT_W = $clog2(DATA_W);

    sdspi_state_t      state;
    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [CNT_W-1:0]  bit_cnt;
    // MSB goes straight to sddo at start, so only the rest is kept
    logic [DATA_W-2:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;

    always_ff @(posedge fclk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            sdclk   <= 1'b0;
            sddo    <= 1'b1;
            sdcs_n  <= 1'b1;
            rx_data <= '0;
            rx_sh   <= '0;
            tx_sh   <= '0;
            div_q   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else begin
            done <= 1'b0;
            // chip select only follows the request between transfers
            if (state == IDLE) begin
                sdcs_n <= cs_req_n;
            end
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= PH_LO;
                        busy    <= 1'b1;
                        sddo    <= tx_data[DATA_W-1];
                        tx_sh   <= tx_data[DATA_W-2:0];
                        div_q   <= clkdiv;
                        div_cnt <= clkdiv;
                        bit_cnt <= CNT_W'(DATA_W - 1);
                    end
                end
                PH_LO: begin
                    if (div_cnt == '0) begin
                        state   <= PH_HI;
                        sdclk   <= 1'b1;
                        rx_sh   <= {rx_sh[DATA_W-2:0], sddi};
                        div_cnt <= div_q;
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                PH_HI: begin
                    if (div_cnt == '0) begin
                        sdclk <= 1'b0;
                        if (bit_cnt == '0) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            sddo    <= 1'b1;
                            rx_data <= rx_sh;
                        end else begin
                            state   <= PH_LO;
                            bit_cnt <= bit_cnt - 1'b1;
                            sddo    <= tx_sh[DATA_W-2];
                            tx_sh   <= {tx_sh[DATA_W-3:0], 1'b0};
                            div_cnt <= div_q;
                        end
                    end else begin
                        div_cnt <= div_cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sdclk <= 1'b0;
                    sddo  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdspi_master.sv
// Bench for sdspi_master: 8-bit instance driven from a vector table,
// random transfers and corner sequences; 16-bit instance in loopback.
module tb_sdspi_master;

    logic        fclk = 1'b0;
    logic        rst;
    logic [7:0]  clkdiv;
    logic        cs_req_n;
    logic        start;
    logic [7:0]  tx_data;
    logic [7:0]  rx_data;
    logic        busy, done, sdcs_n, sdclk, sddo, sddi;

    logic [7:0]  clkdiv16;
    logic        cs16, start16;
    logic [15:0] tx16, rx16;
    logic        busy16, done16, sdcs16, sdclk16, sddo16, sddi16;

    int total = 0;
    int bad   = 0;

    always #5 fclk = ~fclk;

    sdspi_master #(.DATA_W(8), .DIV_W(8)) dut (
        .fclk(fclk), .rst(rst), .clkdiv(clkdiv), .cs_req_n(cs_req_n),
        .start(start), .tx_data(tx_data), .rx_data(rx_data),
        .busy(busy), .done(done), .sdcs_n(sdcs_n), .sdclk(sdclk),
        .sddo(sddo), .sddi(sddi)
    );

    assign sddi16 = sddo16;

    sdspi_master #(.DATA_W(16), .DIV_W(8)) dut16 (
        .fclk(fclk), .rst(rst), .clkdiv(clkdiv16), .cs_req_n(cs16),
        .start(start16), .tx_data(tx16), .rx_data(rx16),
        .busy(busy16), .done(done16), .sdcs_n(sdcs16), .sdclk(sdclk16),
        .sddo(sddo16), .sddi(sddi16)
    );

    typedef struct {
        logic [7:0] tx;
        int         div;
        bit         loop;
        logic [7:0] din;
        logic [7:0] exp_rx;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got %0h want %0h t=%0t",
                         name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge fclk);
        #1;
    endtask

    // Model: in busy cycle k, bit b = k / (2*(div+1)) is on sddo, and
    // sdclk is high in the second half of each bit period.
    task automatic run8(input logic [7:0] tx, input int div,
                        input bit loop, input logic [7:0] din,
                        input logic [7:0] exp_rx, input int poke,
                        input int csflip, input bit chain);
        int   n;
        int   hp;
        int   pulses;
        int   w;
        int   b;
        logic prev;
        logic xb;
        logic eclk;
        logic cs_exp;
        n      = 16 * (div + 1);
        hp     = div + 1;
        pulses = 0;
        w      = 0;
        while (busy && w < 500) begin
            step;
            w++;
        end
        chk("idle_before_start", busy, 0);
        tx_data = tx;
        clkdiv  = 8'(div);
        start   = 1'b1;
        cs_exp  = cs_req_n;
        step;
        start = 1'b0;
        prev  = 1'b0;
        for (int k = 0; k < n; k++) begin
            b    = k / (2 * hp);
            xb   = tx[7-b];
            eclk = (k % (2 * hp)) >= hp;
            chk("busy", busy, 1);
            chk("done_early", done, 0);
            chk("sdclk", sdclk, eclk);
            chk("sddo", sddo, xb);
            chk("sdcs_n_hold", sdcs_n, cs_exp);
            if (sdclk && !prev) pulses++;
            prev = sdclk;
            sddi   = loop ? xb : din[7-b];
            clkdiv = 8'($urandom_range(0, 255));
            if (k == poke) begin
                start   = 1'b1;
                tx_data = ~tx;
            end else begin
                start = 1'b0;
            end
            if (k == csflip) cs_req_n = ~cs_req_n;
            step;
        end
        start = 1'b0;
        chk("done", done, 1);
        chk("busy_end", busy, 0);
        chk("sdclk_end", sdclk, 0);
        chk("sddo_end", sddo, 1);
        chk("rx_data", rx_data, exp_rx);
        chk("sdclk_pulses", pulses, 8);
        chk("sdcs_n_done", sdcs_n, cs_exp);
        if (!chain) begin
            step;
            chk("done_once", done, 0);
            chk("sdcs_n_after", sdcs_n, cs_req_n);
            chk("rx_hold", rx_data, exp_rx);
            if (poke >= 0) begin
                repeat (3) begin
                    step;
                    chk("no_queued_start", busy, 0);
                    chk("no_extra_done", done, 0);
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] rtx;
        logic [7:0] rdin;
        bit         rloop;
        int         cnt;
        int         dones;

        rst      = 1'b1;
        start    = 1'b0;
        cs_req_n = 1'b1;
        tx_data  = 8'h00;
        clkdiv   = 8'h00;
        sddi     = 1'b0;
        start16  = 1'b0;
        cs16     = 1'b1;
        tx16     = 16'h0000;
        clkdiv16 = 8'h00;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sdclk", sdclk, 0);
        chk("rst_sddo", sddo, 1);
        chk("rst_sdcs_n", sdcs_n, 1);
        chk("rst_rx", rx_data, 0);

        start = 1'b1;
        step;
        step;
        chk("start_in_rst", busy, 0);
        rst   = 1'b0;
        start = 1'b0;
        step;
        chk("idle_after_rst", busy, 0);

        vecs[0] = '{8'hA5, 0, 1'b1, 8'h00, 8'hA5};
        vecs[1] = '{8'h00, 3, 1'b0, 8'hFF, 8'hFF};
        vecs[2] = '{8'h3C, 1, 1'b0, 8'h5A, 8'h5A};
        vecs[3] = '{8'hFF, 2, 1'b0, 8'h00, 8'h00};
        vecs[4] = '{8'h81, 0, 1'b0, 8'h7E, 8'h7E};
        foreach (vecs[i])
            run8(vecs[i].tx, vecs[i].div, vecs[i].loop,
                 vecs[i].din, vecs[i].exp_rx, -1, -1, 1'b0);

        // start pulsed mid-transfer is dropped
        run8(8'h5A, 0, 1'b1, 8'h00, 8'h5A, 5, -1, 1'b0);

        // start in the done cycle chains a second transfer
        run8(8'hC3, 1, 1'b1, 8'h00, 8'hC3, -1, -1, 1'b1);
        run8(8'h3C, 0, 1'b1, 8'h00, 8'h3C, -1, -1, 1'b0);

        // chip select request changing mid-transfer waits for done
        cs_req_n = 1'b1;
        step;
        run8(8'h96, 0, 1'b1, 8'h00, 8'h96, -1, 4, 1'b0);
        chk("cs_low_after", sdcs_n, 0);
        cs_req_n = 1'b1;
        step;
        chk("cs_high_idle", sdcs_n, 1);

        for (int i = 0; i < 20; i++) begin
            rtx      = 8'($urandom);
            rdin     = 8'($urandom);
            rloop    = 1'($urandom_range(0, 1));
            cs_req_n = 1'($urandom_range(0, 1));
            run8(rtx, $urandom_range(0, 3), rloop, rdin,
                 rloop ? rtx : rdin, -1, -1, 1'b0);
        end

        // 16-bit loopback, clkdiv=1
        tx16     = 16'h1234;
        clkdiv16 = 8'd1;
        start16  = 1'b1;
        step;
        start16  = 1'b0;
        cnt      = 0;
        while (busy16 && cnt < 200) begin
            cnt++;
            step;
        end
        chk("w16_cycles", cnt, 64);
        chk("w16_done", done16, 1);
        chk("w16_rx", rx16, 16'h1234);

        // reset in the middle of a high sdclk phase
        cs_req_n = 1'b0;
        step;
        chk("cs_low_pre_rst", sdcs_n, 0);
        tx_data = 8'h00;
        clkdiv  = 8'd3;
        start   = 1'b1;
        step;
        start = 1'b0;
        repeat (5) step;
        chk("pre_rst_sdclk", sdclk, 1);
        chk("pre_rst_sddo", sddo, 0);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_sdclk", sdclk, 0);
        chk("rst_mid_sddo", sddo, 1);
        chk("rst_mid_sdcs_n", sdcs_n, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rx", rx_data, 0);
        dones = 0;
        repeat (3) begin
            step;
            if (done) dones++;
        end
        rst = 1'b0;
        repeat (70) begin
            step;
            if (done || busy) dones++;
        end
        chk("rst_no_done", dones, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
